// File: rtl/seq_match_pkg.sv
// Shared types and default sizing for the serial pattern match controller.
package seq_match_pkg;
  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TO_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/seq_match_shift.sv
// Bit history, valid-bit count and length-masked pattern compare.
// hit is combinational and describes the history as it will be after this edge.
module seq_match_shift
  import seq_match_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               shift,
  input  logic               a,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               hit
);
  localparam logic [LEN_W-1:0] FULL = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] hist;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   vcnt;
  logic [LEN_W-1:0]   vcnt_nxt;

  assign hist_nxt = {hist[MAX_LEN-2:0], a};
  assign vcnt_nxt = (vcnt == FULL) ? vcnt : vcnt + 1'b1;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len));
    end
  end

  // Only the newest len bits take part; older history is masked off.
  assign hit = shift & (len != '0) & (vcnt_nxt >= len) &
               (((hist_nxt ^ pattern) & mask) == '0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hist <= '0;
      vcnt <= '0;
    end else if (shift) begin
      hist <= hist_nxt;
      vcnt <= vcnt_nxt;
    end
  end
endmodule

// File: rtl/seq_match_ctrl.sv
// Programmable serial pattern match controller: config latch, arm/abort FSM,
// match counting with target and cycle timeout; detected/done one cycle after the sampling edge.
module seq_match_ctrl
  import seq_match_pkg::*;
#(
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TO_W    = DEF_TO_W,
  localparam int LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  input  logic [TO_W-1:0]    cfg_timeout,
  output logic               cfg_err,
  input  logic               start,
  input  logic               abort,
  input  logic               a,
  input  logic               a_valid,
  output logic               busy,
  output logic               detected,
  output logic               done,
  output logic               timed_out,
  output logic [CNT_W-1:0]   match_count
);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);

  state_t             state;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [CNT_W-1:0]   tgt_q;
  logic [TO_W-1:0]    to_q;
  logic [TO_W-1:0]    to_cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [TO_W-1:0]    to_nxt;
  logic               start_ok;
  logic               shift_en;
  logic               hit;
  logic               tgt_hit;
  logic               to_hit;

  assign cfg_ready = (state == IDLE);
  assign start_ok  = cfg_ready & start & ~cfg_valid & ~cfg_err;
  assign shift_en  = (state == ARMED) & a_valid;
  assign cnt_nxt   = (&match_count) ? match_count : match_count + 1'b1;
  assign to_nxt    = (&to_cnt) ? to_cnt : to_cnt + 1'b1;
  assign tgt_hit   = hit & (tgt_q != '0) & (cnt_nxt == tgt_q);
  assign to_hit    = (to_q != '0) & (to_nxt == to_q);

  seq_match_shift #(.MAX_LEN(MAX_LEN)) u_shift (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_ok),
    .shift   (shift_en),
    .a       (a),
    .pattern (pat_q),
    .len     (len_q),
    .hit     (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      tgt_q       <= '0;
      to_q        <= '0;
      cfg_err     <= 1'b1;
      busy        <= 1'b0;
      detected    <= 1'b0;
      done        <= 1'b0;
      timed_out   <= 1'b0;
      match_count <= '0;
      to_cnt      <= '0;
    end else begin
      detected <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid) begin
            pat_q   <= cfg_pattern;
            len_q   <= cfg_len;
            tgt_q   <= cfg_target;
            to_q    <= cfg_timeout;
            cfg_err <= (cfg_len == '0) || (cfg_len > MAX_LEN_L);
          end else if (start_ok) begin
            state       <= ARMED;
            busy        <= 1'b1;
            match_count <= '0;
            to_cnt      <= '0;
            timed_out   <= 1'b0;
          end
        end
        ARMED: begin
          // Abort drops any match sampled on the same edge.
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            to_cnt <= to_nxt;
            if (hit) begin
              detected    <= 1'b1;
              match_count <= cnt_nxt;
            end
            if (tgt_hit || to_hit) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              timed_out <= ~tgt_hit;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed bench for seq_match_ctrl with a stream-level reference model checked every cycle.
module tb_seq_match_ctrl;
  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 8;
  localparam int TO_W    = 16;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic               clk;
  logic               rst;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_target;
  logic [TO_W-1:0]    cfg_timeout;
  logic               cfg_err;
  logic               start;
  logic               abort;
  logic               a;
  logic               a_valid;
  logic               busy;
  logic               detected;
  logic               done;
  logic               timed_out;
  logic [CNT_W-1:0]   match_count;

  int n_checks = 0;
  int n_err    = 0;

  seq_match_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TO_W(TO_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_target(cfg_target),
    .cfg_timeout(cfg_timeout), .cfg_err(cfg_err), .start(start), .abort(abort),
    .a(a), .a_valid(a_valid), .busy(busy), .detected(detected), .done(done),
    .timed_out(timed_out), .match_count(match_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: keeps the valid bits received since start and re-evaluates
  // the spec rules on every edge.
  bit  m_armed, m_indone, m_err, m_det, m_done, m_timed, chk_en;
  bit  [MAX_LEN-1:0] m_pat;
  int  m_len, m_tgt, m_to, m_cnt, m_cyc;
  bit  q[$];

  task automatic model_step();
    bit hit;
    if (rst) begin
      m_armed = 0; m_indone = 0; m_err = 1; m_det = 0; m_done = 0; m_timed = 0;
      m_pat = '0; m_len = 0; m_tgt = 0; m_to = 0; m_cnt = 0; m_cyc = 0;
      q.delete();
      chk_en = 1;
      return;
    end
    m_det = 0; m_done = 0;
    if (m_indone) begin
      m_indone = 0;
    end else if (!m_armed) begin
      if (cfg_valid) begin
        m_pat = cfg_pattern; m_len = cfg_len; m_tgt = cfg_target; m_to = cfg_timeout;
        m_err = (m_len == 0) || (m_len > MAX_LEN);
      end else if (start && !m_err) begin
        m_armed = 1; m_cnt = 0; m_cyc = 0; m_timed = 0;
        q.delete();
      end
    end else if (abort) begin
      m_armed = 0;
    end else begin
      m_cyc++;
      hit = 0;
      if (a_valid) begin
        q.push_back(a);
        if (q.size() > MAX_LEN) void'(q.pop_front());
        if (q.size() >= m_len) begin
          hit = 1;
          for (int k = 0; k < m_len; k++)
            if (q[q.size() - m_len + k] != m_pat[m_len - 1 - k]) hit = 0;
        end
      end
      if (hit) begin
        m_det = 1;
        if (m_cnt < 255) m_cnt++;
      end
      if (hit && m_tgt != 0 && m_cnt == m_tgt) begin
        m_armed = 0; m_done = 1; m_indone = 1;
      end else if (m_to != 0 && m_cyc == m_to) begin
        m_armed = 0; m_done = 1; m_indone = 1; m_timed = 1;
      end
    end
  endtask

  initial begin
    chk_en = 0;
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (chk_en) begin
        check("m_busy", busy, m_armed);
        check("m_detected", detected, m_det);
        check("m_done", done, m_done);
        check("m_timed_out", timed_out, m_timed);
        check("m_match_count", match_count, m_cnt);
        check("m_cfg_err", cfg_err, m_err);
        check("m_cfg_ready", cfg_ready, !m_armed && !m_indone);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic configure(input logic [7:0] p, input int l, input int t, input int to);
    cfg_valid = 1; cfg_pattern = p; cfg_len = LEN_W'(l);
    cfg_target = CNT_W'(t); cfg_timeout = TO_W'(to);
    cyc();
    cfg_valid = 0;
  endtask

  task automatic arm();
    start = 1; cyc(); start = 0;
  endtask

  task automatic stop();
    abort = 1; cyc(); abort = 0;
  endtask

  task automatic run_stream(output logic [23:0] dm, output int di);
    logic [23:0] s;
    s = 24'b0011_0101_1001_1001_1010_1000;
    dm = '0; di = -1;
    for (int i = 0; i < 24; i++) begin
      a = s[23 - i]; a_valid = 1;
      cyc();
      if (detected) dm[i] = 1'b1;
      if (done && di < 0) di = i;
    end
    a_valid = 0;
    cyc();
  endtask

  logic [23:0] dm;
  int di, k_done, npulse;

  initial begin
    rst = 1; cfg_valid = 0; cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
    cfg_timeout = '0; start = 0; abort = 0; a = 0; a_valid = 0;
    cyc(); cyc();
    check("rst_cfg_err", cfg_err, 1);
    check("rst_busy", busy, 0);
    check("rst_count", match_count, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    rst = 0;
    cyc();

    // len 6, 110011, free-running
    configure(8'b0011_0011, 6, 0, 0); arm();
    run_stream(dm, di);
    check("s6_det_idx", dm, 24'h011000);
    check("s6_count", match_count, 2);
    stop();

    // len 4, 1010, overlapping matches
    configure(8'b0000_1010, 4, 0, 0); arm();
    run_stream(dm, di);
    check("s4_det_idx", dm, 24'h280040);
    check("s4_count", match_count, 3);
    stop();

    // len 4, 1010, target 2
    configure(8'b0000_1010, 4, 2, 0); arm();
    run_stream(dm, di);
    check("tgt_done_idx", di, 19);
    check("tgt_count", match_count, 2);
    check("tgt_timed_out", timed_out, 0);
    check("tgt_idle", busy, 0);

    // timeout 10 with no matches
    configure(8'h0F, 4, 0, 10); arm();
    a = 0; a_valid = 1; k_done = -1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      if (done) begin k_done = k; break; end
    end
    a_valid = 0;
    check("to_done_cycle", k_done, 10);
    check("to_timed_out", timed_out, 1);
    check("to_count", match_count, 0);
    cyc();

    // target and timeout on the same edge
    configure(8'h01, 1, 1, 3); arm();
    a_valid = 0; cyc(); cyc();
    a = 1; a_valid = 1; cyc();
    a_valid = 0;
    check("coin_done", done, 1);
    check("coin_timed_out", timed_out, 0);
    check("coin_count", match_count, 1);
    cyc();

    // abort on the edge of the final pattern bit
    configure(8'h03, 2, 0, 0); arm();
    a = 1; a_valid = 1; cyc();
    abort = 1; cyc();
    abort = 0; a_valid = 0;
    check("abort_detected", detected, 0);
    check("abort_count", match_count, 0);
    check("abort_done", done, 0);
    check("abort_busy", busy, 0);
    cyc();

    // bad lengths and start/config collision
    configure(8'h00, 0, 0, 0);
    check("len0_err", cfg_err, 1);
    arm();
    check("len0_not_armed", busy, 0);
    configure(8'hFF, 9, 0, 0);
    check("len9_err", cfg_err, 1);
    cfg_valid = 1; start = 1; cfg_pattern = 8'b0011_0011; cfg_len = 4'd6;
    cfg_target = '0; cfg_timeout = '0;
    cyc();
    cfg_valid = 0; start = 0;
    check("coll_not_armed", busy, 0);
    check("coll_cfg_err", cfg_err, 0);
    arm();
    check("coll_then_armed", busy, 1);

    // 110011 with invalid gaps between bits
    npulse = 0;
    for (int i = 0; i < 6; i++) begin
      a = (i == 2 || i == 3) ? 1'b0 : 1'b1; a_valid = 1;
      cyc(); if (detected) npulse++;
      a_valid = 0;
      for (int g = 0; g < 2; g++) begin
        a = 1'($urandom_range(0, 1)); cyc(); if (detected) npulse++;
      end
    end
    check("gap_pulses", npulse, 1);
    check("gap_count", match_count, 1);
    stop();

    // match counter saturation
    configure(8'h01, 1, 0, 0); arm();
    a = 1; a_valid = 1;
    repeat (300) cyc();
    check("sat_count", match_count, 255);
    check("sat_detected", detected, 1);
    a_valid = 0;
    stop();

    // reset while armed
    configure(8'h01, 1, 0, 0); arm();
    a = 1; a_valid = 1; cyc(); cyc();
    rst = 1; cyc();
    check("mrst_busy", busy, 0);
    check("mrst_detected", detected, 0);
    check("mrst_count", match_count, 0);
    check("mrst_done", done, 0);
    check("mrst_timed_out", timed_out, 0);
    check("mrst_cfg_err", cfg_err, 1);
    rst = 0; a_valid = 0;
    arm();
    check("mrst_cfg_cleared", busy, 0);
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/seq_match_ctrl.md
Name: seq_match_ctrl

Overview:
Programmable serial-pattern match controller for the single-bit stream path feeding the team's sequence detectors. Software configures a pattern of 1..MAX_LEN bits, a target match count and a cycle timeout, then arms the block. While armed it counts overlapping pattern occurrences on the qualified input stream. It finishes when the target count is reached, the timeout expires, or an abort is received.

Parameters:
MAX_LEN, 8, maximum pattern length in bits
CNT_W, 8, width of the match counter and the target count
TO_W, 16, width of the timeout cycle counter

Ports:
clk  in  1  clock; all logic is on its rising edge
rst  in  1  synchronous reset, active-high
cfg_valid  in  1  configuration write strobe
cfg_ready  out  1  high only in IDLE; a configuration write is accepted when cfg_valid & cfg_ready
cfg_pattern  in  MAX_LEN  pattern; pattern[len-1] is the first bit received, pattern[0] the last
cfg_len  in  $clog2(MAX_LEN+1)  pattern length
cfg_target  in  CNT_W  matches required to finish; 0 = run until abort or timeout
cfg_timeout  in  TO_W  armed-cycle limit; 0 = no timeout
cfg_err  out  1  registered; 1 when the latched cfg_len is 0 or > MAX_LEN
start  in  1  arm request
abort  in  1  disarm request
a  in  1  serial data bit
a_valid  in  1  qualifies a
busy  out  1  high in ARMED
detected  out  1  one-cycle pulse per match
done  out  1  one-cycle pulse on leaving ARMED by target or timeout
timed_out  out  1  sticky flag; cleared by start
match_count  out  CNT_W  matches since the last start; saturates at all-ones

Behaviour:
- Reset values: state IDLE; all outputs 0; config registers 0, so cfg_err = 1 after reset.
- FSM has three states: IDLE, ARMED, DONE.
- IDLE, config write: cfg_valid & cfg_ready latches all cfg_* fields and updates cfg_err on the next edge.
- IDLE, start: start & ~cfg_valid & ~cfg_err moves to ARMED. It also clears the history shift register, valid-bit count, match_count, timeout counter and timed_out.
- IDLE, simultaneous start and cfg_valid: the config write wins and start is ignored.
- IDLE, start while cfg_err = 1: start is ignored.
- ARMED, shift: on each edge with a_valid, hist <= {hist[MAX_LEN-2:0], a}. The valid-bit count increments and saturates at MAX_LEN.
- ARMED, match condition: valid_bits >= len and the new hist[len-1:0] == pattern[len-1:0]. Overlapping matches are counted.
- ARMED, on a match: detected = 1 in the cycle after the edge that sampled the final bit, and match_count increments.
- ARMED, target reached: if cfg_target != 0 and match_count reaches cfg_target on this edge, go to DONE.
- ARMED, timeout: the timeout counter increments every ARMED cycle, whether or not a_valid is high. If cfg_timeout != 0, the counter reaches cfg_timeout and the target is not reached on the same edge, set timed_out and go to DONE.
- ARMED, target and timeout on the same edge: the target wins and timed_out stays 0.
- ARMED, abort: go to IDLE. No done pulse. A match on the same edge is discarded: no detected pulse and no count increment.
- DONE: lasts exactly one cycle with done = 1, then goes to IDLE. match_count and timed_out hold until the next start.
- a_valid = 0 while ARMED: history, detected and match_count are unchanged.
- Reset mid-operation: the next cycle is IDLE with reset values; the latched config is also cleared.
- busy = (state == ARMED), registered.
- Latency: final pattern bit sampled on edge N gives detected, and the match_count update, visible after edge N.

Decomposition:
- Package seq_match_pkg: state enum (IDLE, ARMED, DONE, 2-bit encoding) and the default localparams.
- Sub-module seq_match_shift: holds the history register, valid-bit counter and len-masked compare. Inputs: clear, shift, a, pattern, len. Output: the match flag for the new history.
- The controller FSM, counters and config registers live in seq_match_ctrl.

Test Plan:
- Stream test, len=6, pattern=6'b110011, target=0, timeout=0: drive stream 0011_0101_1001_1001_1010_1000 with a_valid=1 and index 0 first. Required: detected after the bits at index 12 and 16, final match_count=2.
- Same stream with len=4, pattern=4'b1010: detected after index 6, 19 and 21 (overlap), match_count=3.
- len=4, pattern=4'b1010, target=2, same stream: done pulses after index 19, then IDLE. Later bits are not counted, match_count=2, timed_out=0.
- timeout=10, pattern 4'b1111, input all 0: done and timed_out are set after 10 ARMED cycles, match_count=0.
- Target and timeout coinciding on the same edge: timed_out=0.
- abort on the same edge as the final pattern bit: no detected pulse, no count increment, no done, returns to IDLE.
- cfg_len=0 written, then start: cfg_err=1 and state stays IDLE. Start and cfg_valid in the same cycle: config updated, not armed.
- a_valid gaps inside 110011 (bits spread with 0 valid cycles between): still exactly one match.
- rst asserted while ARMED: all outputs 0 on the next cycle.
